// File: rtl/tensor_interface.sv
// tensor_interface: descriptor-driven tensor DMA between a config stream,
// a single-beat AR/R + AW/W/B memory port and an output result stream.
// One element is in flight at a time; an element-wise op is applied on the way.
module tensor_interface (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [106:0] config_in_tdata,
  input  logic         config_in_tvalid,
  output logic         config_in_tready,
  output logic [15:0]  ar_addr,
  output logic         ar_valid,
  input  logic         ar_ready,
  input  logic [31:0]  r_data,
  input  logic         r_last,
  input  logic         r_valid,
  output logic         r_ready,
  output logic [15:0]  aw_addr,
  output logic         aw_valid,
  input  logic         aw_ready,
  output logic [31:0]  w_data,
  output logic         w_last,
  output logic         w_valid,
  input  logic         w_ready,
  input  logic         b_resp,
  input  logic         b_valid,
  output logic         b_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BASE_W = 11;
  localparam int unsigned DIM_W  = 40;
  localparam int unsigned EXT_W  = 10;

  localparam logic [1:0] MODE_READ = 2'b01;
  localparam logic [1:0] MODE_FILL = 2'b10;
  localparam logic [1:0] MODE_COPY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RD_ADDR, S_RD_DATA, S_OUT, S_WR_ADDR, S_WR_DATA, S_WR_RESP
  } state_t;

  // Element-wise operation applied to each element on its way through.
  function automatic logic [DATA_W-1:0] apply_op(input logic [2:0] sel, input logic [DATA_W-1:0] x);
    case (sel)
      3'd1:    return -x;
      3'd2:    return x[DATA_W-1] ? DATA_W'(0) : x;
      3'd3:    return x + DATA_W'(1);
      3'd4:    return {x[DATA_W-2:0], 1'b0};
      3'd5:    return x[DATA_W-1] ? -x : x;
      default: return x;
    endcase
  endfunction

  // One dimension extent; a zero extent counts as one.
  function automatic logic [DIM_W-1:0] extent(input logic [EXT_W-1:0] d);
    return (d == '0) ? DIM_W'(1) : DIM_W'(d);
  endfunction

  state_t              state, state_n;
  logic [1:0]          mode, mode_n;
  logic [2:0]          op, op_n;
  logic [BASE_W-1:0]   rd_base, rd_base_n, wr_base, wr_base_n;
  logic [DIM_W-1:0]    dim, dim_n, num, num_n, idx, idx_n;
  logic [DATA_W-1:0]   elem, elem_n;
  logic                err, err_n;
  logic                accept, is_last, last_n;
  logic                unused_ok;

  assign accept    = config_in_tvalid & config_in_tready;
  assign is_last   = (idx == num - DIM_W'(1));
  // r_last carries no information here (element counting is internal); the
  // error flag is kept for observability from inside the block only.
  assign unused_ok = ^{r_last, err};

  // Next-state and datapath update for the transfer sequencer.
  always_comb begin
    state_n   = state;
    mode_n    = mode;
    op_n      = op;
    rd_base_n = rd_base;
    wr_base_n = wr_base;
    dim_n     = dim;
    num_n     = num;
    idx_n     = idx;
    elem_n    = elem;
    err_n     = err;
    case (state)
      S_IDLE: begin
        if (accept) begin
          mode_n    = config_in_tdata[106:105];
          op_n      = config_in_tdata[104:102];
          rd_base_n = config_in_tdata[101:91];
          wr_base_n = config_in_tdata[50:40];
          dim_n     = (config_in_tdata[106:105] == MODE_FILL) ? config_in_tdata[39:0]
                                                              : config_in_tdata[90:51];
          err_n     = 1'b0;
          state_n   = S_SETUP;
        end
      end
      S_SETUP: begin
        num_n  = extent(dim[9:0]) * extent(dim[19:10]) * extent(dim[29:20]) * extent(dim[39:30]);
        idx_n  = '0;
        elem_n = apply_op(op, DATA_W'(0));
        case (mode)
          MODE_READ, MODE_COPY: state_n = S_RD_ADDR;
          MODE_FILL:            state_n = S_WR_ADDR;
          default:              state_n = S_IDLE;
        endcase
      end
      S_RD_ADDR: if (ar_ready) state_n = S_RD_DATA;
      S_RD_DATA: begin
        if (r_valid) begin
          elem_n  = apply_op(op, r_data);
          state_n = (mode == MODE_COPY) ? S_WR_ADDR : S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          idx_n   = idx + DIM_W'(1);
          state_n = is_last ? S_IDLE : S_RD_ADDR;
        end
      end
      S_WR_ADDR: if (aw_ready) state_n = S_WR_DATA;
      S_WR_DATA: if (w_ready) state_n = S_WR_RESP;
      S_WR_RESP: begin
        if (b_valid) begin
          if (b_resp) err_n = 1'b1;
          idx_n = idx + DIM_W'(1);
          if (is_last)                 state_n = S_IDLE;
          else if (mode == MODE_COPY)  state_n = S_RD_ADDR;
          else                         state_n = S_WR_ADDR;
        end
      end
      default: state_n = S_IDLE;
    endcase
    last_n = (idx_n == num_n - DIM_W'(1));
  end

  // State, descriptor and registered bus outputs derived from the next state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      mode             <= '0;
      op               <= '0;
      rd_base          <= '0;
      wr_base          <= '0;
      dim              <= '0;
      num              <= '0;
      idx              <= '0;
      elem             <= '0;
      err              <= 1'b0;
      config_in_tready <= 1'b0;
      ar_addr          <= '0;
      ar_valid         <= 1'b0;
      r_ready          <= 1'b0;
      aw_addr          <= '0;
      aw_valid         <= 1'b0;
      w_data           <= '0;
      w_last           <= 1'b0;
      w_valid          <= 1'b0;
      b_ready          <= 1'b0;
      out_data         <= '0;
      out_last         <= 1'b0;
      out_valid        <= 1'b0;
    end else begin
      state            <= state_n;
      mode             <= mode_n;
      op               <= op_n;
      rd_base          <= rd_base_n;
      wr_base          <= wr_base_n;
      dim              <= dim_n;
      num              <= num_n;
      idx              <= idx_n;
      elem             <= elem_n;
      err              <= err_n;
      config_in_tready <= (state_n == S_IDLE);
      ar_addr          <= ADDR_W'(rd_base) + idx_n[ADDR_W-1:0];
      ar_valid         <= (state_n == S_RD_ADDR);
      r_ready          <= (state_n == S_RD_DATA);
      aw_addr          <= ADDR_W'(wr_base) + idx_n[ADDR_W-1:0];
      aw_valid         <= (state_n == S_WR_ADDR);
      w_data           <= elem_n;
      w_last           <= (state_n == S_WR_DATA) && last_n;
      w_valid          <= (state_n == S_WR_DATA);
      b_ready          <= (state_n == S_WR_RESP);
      out_data         <= elem_n;
      out_last         <= (state_n == S_OUT) && last_n;
      out_valid        <= (state_n == S_OUT);
    end
  end

endmodule

// File: tb/tb_tensor_interface.sv
// tb_tensor_interface: randomized memory/stream responder plus a
// transaction-level reference model of the tensor DMA.
module tb_tensor_interface;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [106:0] config_in_tdata = '0;
  logic         config_in_tvalid = 1'b0;
  logic         config_in_tready;
  logic [15:0]  ar_addr;
  logic         ar_valid;
  logic         ar_ready = 1'b0;
  logic [31:0]  r_data = '0;
  logic         r_last = 1'b0;
  logic         r_valid = 1'b0;
  logic         r_ready;
  logic [15:0]  aw_addr;
  logic         aw_valid;
  logic         aw_ready = 1'b0;
  logic [31:0]  w_data;
  logic         w_last;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic         b_resp = 1'b0;
  logic         b_valid = 1'b0;
  logic         b_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         out_valid;
  logic         out_ready = 1'b0;

  tensor_interface dut (
    .clock(clock), .reset_n(reset_n),
    .config_in_tdata(config_in_tdata), .config_in_tvalid(config_in_tvalid),
    .config_in_tready(config_in_tready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Responder knobs and per-descriptor observations.
  int rdy_pct = 100;
  int stall_idx = -1;
  int stall_len = 0;
  bit w_never = 1'b0;
  bit bresp_rand = 1'b0;
  int hs_cyc, first_ar_cyc, last_hs_cyc, done_cyc;
  bit timed_out;
  logic [15:0] ar_q[$];
  logic [15:0] aw_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] w_q[$];
  logic [31:0] out_q[$];
  logic        wl_q[$];
  logic        outl_q[$];
  logic [31:0] src_q[$];

  // Reference element operation, in plain unsigned arithmetic modulo 2^32.
  function automatic logic [31:0] ref_op(input logic [2:0] sel, input logic [31:0] x);
    longint unsigned lx, m;
    lx = longint'(x);
    m  = 64'h1_0000_0000;
    case (sel)
      3'd1: return 32'((m - lx) % m);
      3'd2: return (lx >= 64'h8000_0000) ? 32'd0 : x;
      3'd3: return 32'((lx + 1) % m);
      3'd4: return 32'((lx * 2) % m);
      3'd5: return (lx >= 64'h8000_0000) ? 32'((m - lx) % m) : x;
      default: return x;
    endcase
  endfunction

  // Reference element count: product of four 10-bit extents, zero meaning one.
  function automatic longint unsigned ref_count(input logic [39:0] d);
    longint unsigned p, e;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      e = longint'((d >> (10 * k)) & 40'h3FF);
      p = p * ((e == 0) ? 1 : e);
    end
    return p;
  endfunction

  function automatic bit roll();
    return $urandom_range(99) < rdy_pct;
  endfunction

  // Issue one descriptor and act as memory and stream sink until the block
  // returns to idle, recording every handshake and checking payload stability.
  task automatic run_desc(input logic [1:0] rw, input logic [2:0] op, input logic [10:0] rb,
                          input logic [39:0] rdim, input logic [10:0] wb, input logic [39:0] wdim,
                          input int limit, input bit allow_to);
    bit pend_r, pend_b, ar_st, aw_st, w_st, o_st;
    logic [31:0] pend_data, w_prev, o_prev;
    logic [15:0] ar_prev, aw_prev;
    logic wl_prev, ol_prev;
    int stalled, n;
    pend_r = 0; pend_b = 0; ar_st = 0; aw_st = 0; w_st = 0; o_st = 0;
    pend_data = '0; w_prev = '0; o_prev = '0; ar_prev = '0; aw_prev = '0;
    wl_prev = 0; ol_prev = 0; stalled = 0;
    ar_q.delete(); aw_q.delete(); rd_q.delete(); w_q.delete(); out_q.delete();
    wl_q.delete(); outl_q.delete();
    first_ar_cyc = -1; last_hs_cyc = -1; done_cyc = -1; timed_out = 0;
    n = 0;
    @(negedge clock);
    while (!config_in_tready && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (!config_in_tready) begin
      vectors++; miscompares++; timed_out = 1;
      $display("FAIL accept_wait: config_in_tready got %b want 1", config_in_tready);
      return;
    end
    config_in_tdata  = {rw, op, rb, rdim, wb, wdim};
    config_in_tvalid = 1'b1;
    hs_cyc = cyc;
    @(negedge clock);
    config_in_tvalid = 1'b0;
    n = 0;
    forever begin
      if (config_in_tready) begin
        done_cyc = cyc;
        break;
      end
      if (n >= limit) begin
        timed_out = 1;
        if (!allow_to) begin
          vectors++; miscompares++;
          $display("FAIL done_timeout: busy after %0d cycles want idle", n);
        end
        break;
      end
      n++;
      if (ar_st) begin
        vectors++;
        if (ar_valid !== 1'b1 || ar_addr !== ar_prev) begin
          miscompares++;
          $display("FAIL ar_hold: got v=%b a=%h want v=1 a=%h", ar_valid, ar_addr, ar_prev);
        end
      end
      if (aw_st) begin
        vectors++;
        if (aw_valid !== 1'b1 || aw_addr !== aw_prev) begin
          miscompares++;
          $display("FAIL aw_hold: got v=%b a=%h want v=1 a=%h", aw_valid, aw_addr, aw_prev);
        end
      end
      if (w_st) begin
        vectors++;
        if (w_valid !== 1'b1 || w_data !== w_prev || w_last !== wl_prev) begin
          miscompares++;
          $display("FAIL w_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   w_valid, w_data, w_last, w_prev, wl_prev);
        end
      end
      if (o_st) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== o_prev || out_last !== ol_prev) begin
          miscompares++;
          $display("FAIL out_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   out_valid, out_data, out_last, o_prev, ol_prev);
        end
      end
      vectors++;
      if ($countones({ar_valid, r_ready, aw_valid, w_valid, b_ready, out_valid}) > 1) begin
        miscompares++;
        $display("FAIL single_outstanding: active set %b want at most one",
                 {ar_valid, r_ready, aw_valid, w_valid, b_ready, out_valid});
      end
      if (ar_valid && first_ar_cyc < 0) first_ar_cyc = cyc;
      ar_ready = roll();
      aw_ready = roll();
      w_ready  = w_never ? 1'b0 : roll();
      if (out_valid && out_q.size() == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = roll();
      end
      r_valid = pend_r && roll();
      r_data  = pend_r ? pend_data : $urandom;
      b_valid = pend_b && roll();
      b_resp  = bresp_rand ? 1'($urandom_range(1)) : 1'b0;
      if (r_valid && r_ready) begin
        rd_q.push_back(r_data);
        pend_r = 0;
      end
      if (ar_valid && ar_ready) begin
        ar_q.push_back(ar_addr);
        pend_r = 1;
        pend_data = (src_q.size() > 0) ? src_q.pop_front() : $urandom;
      end
      if (b_valid && b_ready) begin
        pend_b = 0;
        last_hs_cyc = cyc;
      end
      if (aw_valid && aw_ready) aw_q.push_back(aw_addr);
      if (w_valid && w_ready) begin
        w_q.push_back(w_data);
        wl_q.push_back(w_last);
        pend_b = 1;
      end
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        outl_q.push_back(out_last);
        last_hs_cyc = cyc;
      end
      ar_st = ar_valid && !ar_ready;  ar_prev = ar_addr;
      aw_st = aw_valid && !aw_ready;  aw_prev = aw_addr;
      w_st  = w_valid && !w_ready;    w_prev = w_data;  wl_prev = w_last;
      o_st  = out_valid && !out_ready; o_prev = out_data; ol_prev = out_last;
      @(negedge clock);
    end
    ar_ready = 0; aw_ready = 0; w_ready = 0; out_ready = 0; r_valid = 0; b_valid = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      vectors++;
      if ({config_in_tready, ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_last,
           w_valid, b_ready, out_data, out_last, out_valid} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: cycle %0d some output nonzero or X", k);
      end
    end
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (config_in_tready !== 1'b1 || ar_valid !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: tready=%b ar_valid=%b out_valid=%b want 1 0 0",
               config_in_tready, ar_valid, out_valid);
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] exp_d[4];
    exp_d = '{32'hA, 32'hB, 32'hC, 32'hD};
    rdy_pct = 100;
    src_q = '{32'hA, 32'hB, 32'hC, 32'hD};
    run_desc(2'b01, 3'd0, 11'h010, 40'd4, 11'h000, 40'd0, 200, 0);
    vectors++;
    if (first_ar_cyc - hs_cyc !== 2) begin
      miscompares++;
      $display("FAIL read_ar_latency: got %0d want 2", first_ar_cyc - hs_cyc);
    end
    vectors++;
    if (ar_q.size() !== 4 || out_q.size() !== 4 || aw_q.size() !== 0) begin
      miscompares++;
      $display("FAIL read_counts: ar=%0d out=%0d aw=%0d want 4 4 0",
               ar_q.size(), out_q.size(), aw_q.size());
    end
    for (int k = 0; k < 4 && k < out_q.size() && k < ar_q.size(); k++) begin
      vectors++;
      if (ar_q[k] !== 16'(16'h010 + k) || out_q[k] !== exp_d[k] || outl_q[k] !== (k == 3)) begin
        miscompares++;
        $display("FAIL read_elem%0d: got a=%h d=%h l=%b want a=%h d=%h l=%b",
                 k, ar_q[k], out_q[k], outl_q[k], 16'(16'h010 + k), exp_d[k], (k == 3));
      end
    end
  endtask

  task automatic test_read_relu();
    rdy_pct = 100;
    src_q = '{32'hFFFF_FFF0, 32'h5};
    run_desc(2'b01, 3'd2, 11'h020, 40'd2, 11'h000, 40'd0, 200, 0);
    vectors++;
    if (out_q.size() !== 2) begin
      miscompares++;
      $display("FAIL relu_count: got %0d want 2", out_q.size());
    end else begin
      vectors++;
      if (out_q[0] !== 32'h0 || out_q[1] !== 32'h5) begin
        miscompares++;
        $display("FAIL relu_data: got %h %h want 00000000 00000005", out_q[0], out_q[1]);
      end
    end
  endtask

  task automatic test_read_stall();
    logic [31:0] s[3];
    for (int k = 0; k < 3; k++) s[k] = $urandom;
    rdy_pct = 100;
    stall_idx = 1;
    stall_len = 4;
    src_q = '{s[0], s[1], s[2]};
    run_desc(2'b01, 3'd0, 11'h100, 40'd3, 11'h000, 40'd0, 200, 0);
    stall_idx = -1;
    stall_len = 0;
    vectors++;
    if (out_q.size() !== 3 || ar_q.size() !== 3) begin
      miscompares++;
      $display("FAIL stall_counts: out=%0d ar=%0d want 3 3", out_q.size(), ar_q.size());
    end
    for (int k = 0; k < 3 && k < out_q.size(); k++) begin
      vectors++;
      if (out_q[k] !== s[k] || outl_q[k] !== (k == 2)) begin
        miscompares++;
        $display("FAIL stall_elem%0d: got d=%h l=%b want d=%h l=%b",
                 k, out_q[k], outl_q[k], s[k], (k == 2));
      end
    end
  endtask

  task automatic test_copy();
    rdy_pct = 100;
    run_desc(2'b11, 3'd3, 11'h7FF, 40'd2, 11'h100, 40'($urandom), 200, 0);
    vectors++;
    if (ar_q.size() !== 2 || aw_q.size() !== 2 || w_q.size() !== 2 || rd_q.size() !== 2 ||
        out_q.size() !== 0) begin
      miscompares++;
      $display("FAIL copy_counts: ar=%0d aw=%0d w=%0d rd=%0d out=%0d want 2 2 2 2 0",
               ar_q.size(), aw_q.size(), w_q.size(), rd_q.size(), out_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (ar_q[k] !== 16'(16'h7FF + k) || aw_q[k] !== 16'(16'h100 + k) ||
            w_q[k] !== 32'(rd_q[k] + 32'd1) || wl_q[k] !== (k == 1)) begin
          miscompares++;
          $display("FAIL copy_elem%0d: got ar=%h aw=%h w=%h l=%b want ar=%h aw=%h w=%h l=%b",
                   k, ar_q[k], aw_q[k], w_q[k], wl_q[k], 16'(16'h7FF + k), 16'(16'h100 + k),
                   32'(rd_q[k] + 32'd1), (k == 1));
        end
      end
    end
  endtask

  task automatic test_fill_reset();
    logic [2:0] op;
    op = 3'($urandom_range(7));
    rdy_pct = 100;
    w_never = 1'b1;
    run_desc(2'b10, op, 11'h300, 40'($urandom), 11'h040, 40'd3, 15, 1);
    w_never = 1'b0;
    vectors++;
    if (!timed_out || aw_q.size() !== 1 || w_valid !== 1'b1 || w_data !== ref_op(op, 32'd0) ||
        w_last !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_stuck: to=%b aw=%0d wv=%b wd=%h wl=%b want 1 1 1 %h 0",
               timed_out, aw_q.size(), w_valid, w_data, w_last, ref_op(op, 32'd0));
    end
    vectors++;
    if (aw_q.size() > 0 && aw_q[0] !== 16'h040) begin
      miscompares++;
      $display("FAIL fill_aw: got %h want 0040", aw_q[0]);
    end
    reset_n = 1'b0;
    @(negedge clock);
    vectors++;
    if ({config_in_tready, ar_valid, r_ready, aw_valid, w_data, w_last, w_valid, b_ready,
         out_data, out_last, out_valid, ar_addr, aw_addr} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: some output nonzero want all 0");
    end
    reset_n = 1'b1;
    ar_ready = 1; aw_ready = 1; w_ready = 1; out_ready = 1;
    @(negedge clock);
    vectors++;
    if (config_in_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_idle: tready got %b want 1", config_in_tready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      vectors++;
      if ({ar_valid, aw_valid, w_valid, b_ready, r_ready, out_valid} !== '0 ||
          config_in_tready !== 1'b1) begin
        miscompares++;
        $display("FAIL midreset_quiet: valids %b tready %b want 000000 1",
                 {ar_valid, aw_valid, w_valid, b_ready, r_ready, out_valid}, config_in_tready);
      end
    end
    ar_ready = 0; aw_ready = 0; w_ready = 0; out_ready = 0;
  endtask

  task automatic test_random();
    logic [1:0] rw;
    logic [2:0] op;
    logic [10:0] rb, wb;
    logic [39:0] dim, junk;
    int n, nr, nw, no;
    rdy_pct = 70;
    bresp_rand = 1'b1;
    for (int t = 0; t < 20; t++) begin
      rw = 2'($urandom_range(3));
      op = 3'($urandom_range(7));
      rb = 11'($urandom);
      wb = 11'($urandom);
      dim = {10'd0, 10'($urandom_range(1)), 10'($urandom_range(2)), 10'($urandom_range(4))};
      junk = {8'($urandom), 32'($urandom)};
      n = int'(ref_count(dim));
      if (rw == 2'b10) run_desc(rw, op, rb, junk, wb, dim, 500, 0);
      else             run_desc(rw, op, rb, dim, wb, junk, 500, 0);
      nr = (rw[0]) ? n : 0;
      nw = (rw[1]) ? n : 0;
      no = (rw == 2'b01) ? n : 0;
      vectors++;
      if (ar_q.size() !== nr || rd_q.size() !== nr || aw_q.size() !== nw || w_q.size() !== nw ||
          out_q.size() !== no) begin
        miscompares++;
        $display("FAIL rand%0d_counts: ar=%0d rd=%0d aw=%0d w=%0d out=%0d want %0d %0d %0d %0d %0d",
                 t, ar_q.size(), rd_q.size(), aw_q.size(), w_q.size(), out_q.size(),
                 nr, nr, nw, nw, no);
        continue;
      end
      for (int k = 0; k < n; k++) begin
        if (rw[0]) begin
          vectors++;
          if (ar_q[k] !== 16'(rb + k)) begin
            miscompares++;
            $display("FAIL rand%0d_ar%0d: got %h want %h", t, k, ar_q[k], 16'(rb + k));
          end
        end
        if (rw == 2'b01) begin
          vectors++;
          if (out_q[k] !== ref_op(op, rd_q[k]) || outl_q[k] !== (k == n - 1)) begin
            miscompares++;
            $display("FAIL rand%0d_out%0d: got d=%h l=%b want d=%h l=%b", t, k, out_q[k],
                     outl_q[k], ref_op(op, rd_q[k]), (k == n - 1));
          end
        end
        if (rw[1]) begin
          vectors++;
          if (aw_q[k] !== 16'(wb + k) || wl_q[k] !== (k == n - 1) ||
              w_q[k] !== ref_op(op, (rw == 2'b11) ? rd_q[k] : 32'd0)) begin
            miscompares++;
            $display("FAIL rand%0d_w%0d: got a=%h d=%h l=%b want a=%h d=%h l=%b", t, k, aw_q[k],
                     w_q[k], wl_q[k], 16'(wb + k), ref_op(op, (rw == 2'b11) ? rd_q[k] : 32'd0),
                     (k == n - 1));
          end
        end
      end
    end
    bresp_rand = 1'b0;
    rdy_pct = 100;
  endtask

  task automatic test_back_to_back();
    logic [1:0] modes[3];
    modes = '{2'b01, 2'b10, 2'b11};
    rdy_pct = 100;
    for (int t = 0; t < 3; t++) begin
      run_desc(modes[t], 3'($urandom_range(7)), 11'($urandom), 40'd2, 11'($urandom), 40'd2, 200, 0);
      vectors++;
      if (done_cyc - last_hs_cyc !== 1) begin
        miscompares++;
        $display("FAIL b2b_tready%0d: got %0d cycles want 1", t, done_cyc - last_hs_cyc);
      end
    end
    run_desc(2'b00, 3'd0, 11'h0, 40'd5, 11'h0, 40'd5, 50, 0);
    vectors++;
    if (done_cyc - hs_cyc !== 2 || ar_q.size() !== 0 || aw_q.size() !== 0) begin
      miscompares++;
      $display("FAIL nop_return: got %0d cycles ar=%0d aw=%0d want 2 0 0",
               done_cyc - hs_cyc, ar_q.size(), aw_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_relu();
    test_read_stall();
    test_copy();
    test_fill_reset();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tensor_interface.md
Name: tensor_interface

Overview:
- Configurable tensor DMA engine between a config stream, a simplified single-beat AXI-like memory port (AR/R, AW/W/B) and an output data stream.
- Each accepted 107-bit descriptor moves one tensor element by element: read-to-stream, write-fill, or read-modify-write copy.
- An element-wise operation is applied on the way through.
- Sits between the tensor-dialect command issuer and on-chip tensor memory.

Parameters:
- none (all widths fixed as below)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- config_in_tdata  in  107  descriptor: [106:105] rd_wr, [104:102] operation, [101:91] rd_base_addr, [90:51] rd_dim, [50:40] wr_base_addr, [39:0] wr_dim
- config_in_tvalid / config_in_tready  in/out  1  descriptor handshake
- ar_addr  out  16  read address; ar_valid out 1; ar_ready in 1
- r_data  in  32  read data; r_last in 1 (ignored); r_valid in 1; r_ready out 1
- aw_addr  out  16  write address; aw_valid out 1; aw_ready in 1
- w_data  out  32  write data; w_last out 1; w_valid out 1; w_ready in 1
- b_resp  in  1  write response, 1 = error; b_valid in 1; b_ready out 1
- out_data  out  32  result stream; out_last out 1; out_valid out 1; out_ready in 1

Behaviour:
- Reset: reset_n sampled on the rising edge of clock (synchronous, active-low). While low, every output is 0, including config_in_tready. Reset mid-operation aborts the descriptor with no further bus activity.
- Dim field: four 10-bit extents {d3,d2,d1,d0}; an extent of 0 counts as 1. Element count N = d0*d1*d2*d3, 40-bit unsigned.
- rd_wr decode:
  - 01: READ. Read N elements from rd_base_addr and stream them on out_*.
  - 10: FILL. Write N zero elements (operation still applied) to wr_base_addr.
  - 11: COPY. Read from rd_base_addr, apply the op, write to wr_base_addr. N comes from rd_dim; wr_dim is ignored.
  - 00: NOP. Accepted, then the block returns to IDLE next cycle.
- operation on the 32-bit element x:
  - 0: pass
  - 1: two's-complement negate
  - 2: relu (signed x<0 gives 0)
  - 3: x+1, wraps
  - 4: x<<1
  - 5: abs, 0x80000000 stays 0x80000000
  - 6, 7: pass
- Address for element i = zero-extended base + i, truncated to 16 bits (wraps at 0xFFFF).
- States: IDLE, SETUP, RD_ADDR, RD_DATA, OUT, WR_ADDR, WR_DATA, WR_RESP.
- IDLE:
  - config_in_tready=1 only in IDLE.
  - On tvalid&tready: latch the descriptor and go to SETUP.
- SETUP (1 cycle): register N and set i=0. Then:
  - READ/COPY go to RD_ADDR.
  - FILL goes to WR_ADDR.
  - NOP goes to IDLE.
- RD_ADDR: ar_valid=1 with ar_addr stable. On ar_ready, go to RD_DATA. First ar_valid appears 2 cycles after the config handshake edge.
- RD_DATA: r_ready=1. On r_valid, capture op(r_data). READ goes to OUT; COPY goes to WR_ADDR.
- OUT:
  - out_valid=1, out_data held.
  - out_last=1 when i==N-1.
  - On out_ready: i++. If i was N-1 go to IDLE, else go to RD_ADDR.
- WR_ADDR: aw_valid=1. On aw_ready, go to WR_DATA.
- WR_DATA: w_valid=1, w_data held, w_last=1 when i==N-1. On w_ready, go to WR_RESP.
- WR_RESP:
  - b_ready=1. On b_valid: i++; last element goes to IDLE, else go to RD_ADDR (COPY) or WR_ADDR (FILL).
  - b_resp=1 sets a sticky internal error flag, cleared on the next accept, and does not stop the transfer.
- Exactly one outstanding transaction at a time. All valids stay asserted with stable payload until the handshake. Valid never waits on ready.
- r_last is ignored: element counting is internal. r_data arriving outside RD_DATA is not accepted (r_ready=0).
- Back-to-back descriptors: config_in_tready reasserts the cycle after the final handshake.

Test Plan:
- Reset held 5 cycles, then released -> all outputs 0 during reset; config_in_tready=1 the first cycle after release.
- READ, op=0, rd_base=0x010, rd_dim d0=4 (others 0), ar_ready and out_ready tied 1, r_data=0xA,0xB,0xC,0xD -> ar_addr 0x010..0x013; out_data 0xA..0xD; out_last only on 0xD; IDLE afterwards.
- READ, op=2 (relu), N=2, r_data=0xFFFFFFF0 then 0x5 -> out_data 0x0 then 0x5.
- READ, N=3, out_ready stalled 4 cycles on element 1 -> out_data/out_valid stable; no new ar_valid until accepted; config_in_tready=0 throughout.
- COPY, op=3, rd_base=0x7FF, wr_base=0x100, N=2, all readies 1, b_resp=0 -> ar_addr 0x7FF,0x800; aw_addr 0x100,0x101; w_data=r_data+1; w_last on 2nd beat.
- FILL, N=3, w_ready never asserted -> w_valid stays high with first beat; reset_n pulsed low mid-transfer -> all outputs 0 and block returns to IDLE.
